// File: rtl/ordena9.sv
// Nine-element odd-even transposition sorter: load on reset, one phase per clock.
// Optional build macro ORDENA9_EARLY_EXIT_EN stops after two consecutive swap-free phases.

module ordena9_cas #(
   parameter int WIDTH = 8
) (
   input  logic             i_en,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_swp
);
   assign o_swp = i_en && (i_a > i_b);
endmodule

module ordena9 #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] entrada [8:0],
   output logic [WIDTH-1:0] saida   [8:0],
   output logic             flag
);
   typedef enum logic {SORT, DONE} state_t;

   state_t           r_state;
   logic [3:0]       r_phase;
   logic             r_flag;
   logic [WIDTH-1:0] r_d   [8:0];
   logic [WIDTH-1:0] w_nxt [8:0];
   logic [7:0]       w_swp;
   logic             w_done;

   // Pair (i,i+1) is active when i's parity matches the phase parity.
   genvar i;
   generate
      for (i = 0; i < 8; i++) begin : g_cas
         ordena9_cas #(.WIDTH(WIDTH)) u_cas (
            .i_en  ((i % 2 == 1) ? r_phase[0] : ~r_phase[0]),
            .i_a   (r_d[i]),
            .i_b   (r_d[i+1]),
            .o_swp (w_swp[i])
         );
      end
      for (i = 0; i < 9; i++) begin : g_nxt
         if (i == 0) begin : g_first
            assign w_nxt[i] = w_swp[0] ? r_d[1] : r_d[0];
         end else if (i == 8) begin : g_last
            assign w_nxt[i] = w_swp[7] ? r_d[7] : r_d[8];
         end else begin : g_mid
            assign w_nxt[i] = w_swp[i]   ? r_d[i+1] :
                              w_swp[i-1] ? r_d[i-1] : r_d[i];
         end
         assign saida[i] = r_d[i];
      end
   endgenerate

`ifdef ORDENA9_EARLY_EXIT_EN
   logic r_quiet;
   assign w_done = (r_phase == 4'd8) || (r_quiet && (w_swp == 8'd0));
`else
   assign w_done = (r_phase == 4'd8);
`endif

   assign flag = r_flag;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_d     <= entrada;
         r_phase <= 4'd0;
         r_state <= SORT;
         r_flag  <= 1'b0;
`ifdef ORDENA9_EARLY_EXIT_EN
         r_quiet <= 1'b0;
`endif
      end else begin
         case (r_state)
            SORT: begin
               r_d     <= w_nxt;
               r_phase <= r_phase + 4'd1;
`ifdef ORDENA9_EARLY_EXIT_EN
               r_quiet <= (w_swp == 8'd0);
`endif
               if (w_done) begin
                  r_state <= DONE;
                  r_flag  <= 1'b1;
               end
            end
            default: ;  // DONE: result frozen until the next load
         endcase
      end
   end
endmodule

// File: tb/tb_ordena9.sv
// Scoreboard bench for ordena9: expected sorted vectors/latencies queued at load time.
module tb_ordena9;
   typedef logic [7:0] vec_t [8:0];
   typedef struct { vec_t v; int lat; } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic [7:0] entrada [8:0];
   logic [7:0] saida   [8:0];
   logic flag;

   int checks = 0;
   int failures = 0;
   exp_t sb[$];
   exp_t last;

   ordena9 #(.WIDTH(8)) dut (
      .clk(clk), .reset(reset), .entrada(entrada), .saida(saida), .flag(flag)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
      vec_t v;
      v[0] = a0[7:0]; v[1] = a1[7:0]; v[2] = a2[7:0]; v[3] = a3[7:0];
      v[4] = a4[7:0]; v[5] = a5[7:0]; v[6] = a6[7:0]; v[7] = a7[7:0];
      v[8] = a8[7:0];
      return v;
   endfunction

   function automatic vec_t rnd_vec();
      vec_t v;
      for (int k = 0; k < 9; k++) v[k] = 8'($urandom_range(0, 255));
      return v;
   endfunction

   // Reference: insertion sort
   function automatic vec_t sort_ref(input vec_t v);
      vec_t s = v;
      for (int a = 1; a < 9; a++) begin
         logic [7:0] key = s[a];
         int b = a - 1;
         while (b >= 0 && s[b] > key) begin
            s[b+1] = s[b];
            b--;
         end
         s[b+1] = key;
      end
      return s;
   endfunction

   function automatic int lat_ref(input vec_t v);
`ifdef ORDENA9_EARLY_EXIT_EN
      vec_t d = v;
      bit quiet = 0;
      for (int p = 0; p < 9; p++) begin
         bit sw = 0;
         for (int k = p % 2; k < 8; k += 2)
            if (d[k] > d[k+1]) begin
               logic [7:0] t = d[k];
               d[k] = d[k+1]; d[k+1] = t; sw = 1;
            end
         if (p == 8 || (!sw && quiet)) return p + 1;
         quiet = !sw;
      end
      return 9;
`else
      return 9;
`endif
   endfunction

   function automatic bit vec_eq(input vec_t a, input vec_t b);
      for (int k = 0; k < 9; k++) if (a[k] !== b[k]) return 0;
      return 1;
   endfunction

   function automatic string fmt(input vec_t v);
      string s = "";
      for (int k = 0; k < 9; k++) s = {s, $sformatf("%02h ", v[k])};
      return s;
   endfunction

   // One reset edge loading v; checks flag clear and raw load, queues expectation.
   task automatic load(input string name, input vec_t v);
      exp_t e;
      @(negedge clk);
      entrada = v;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if (flag !== 1'b0) begin
         failures++;
         $display("FAIL %s load_flag: got %b want 0", name, flag);
      end
      checks++;
      if (!vec_eq(saida, v)) begin
         failures++;
         $display("FAIL %s load_raw: got %s want %s", name, fmt(saida), fmt(v));
      end
      e.v = sort_ref(v);
      e.lat = lat_ref(v);
      sb.push_back(e);
   endtask

   // Clock until flag (bounded), then compare latency and result with the queue head.
   task automatic run_check(input string name);
      exp_t e;
      int n = 0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         n = k;
         if (flag === 1'b1) break;
      end
      if (flag !== 1'b1) n = 99;
      e = sb.pop_front();
      last = e;
      checks++;
      if (n != e.lat) begin
         failures++;
         $display("FAIL %s latency: got %0d edges want %0d", name, n, e.lat);
      end
      checks++;
      if (!vec_eq(saida, e.v)) begin
         failures++;
         $display("FAIL %s result: got %s want %s", name, fmt(saida), fmt(e.v));
      end
   endtask

   task automatic test_reset();
      load("reset", mk(5, 0, 255, 5, 1, 2, 3, 4, 6));
      void'(sb.pop_front());
   endtask

   task automatic test_reverse();
      load("reverse", mk(9, 8, 7, 6, 5, 4, 3, 2, 1));
      run_check("reverse");
   endtask

   task automatic test_random();
      load("random", mk('h3C, 'hFF, 'h00, 'h7A, 'h3C, 'h01, 'h80, 'hFE, 'h10));
      run_check("random");
   endtask

   task automatic test_sorted();
      load("sorted", mk(1, 2, 3, 4, 5, 6, 7, 8, 9));
`ifdef ORDENA9_EARLY_EXIT_EN
      checks++;
      if (sb[0].lat != 2) begin
         failures++;
         $display("FAIL sorted model_latency: got %0d want 2", sb[0].lat);
      end
`endif
      run_check("sorted");
      load("equal", mk(7, 7, 7, 7, 7, 7, 7, 7, 7));
      run_check("equal");
   endtask

   task automatic test_midsort();
      vec_t b = mk('hFF, 0, 'h80, 'h7F, 1, 'hFE, 'h40, 2, 'h40);
      load("mid_a", mk(9, 8, 7, 6, 5, 4, 3, 2, 1));
      repeat (4) @(negedge clk);
      checks++;
      if (flag !== 1'b0) begin
         failures++;
         $display("FAIL mid_a running_flag: got %b want 0", flag);
      end
      void'(sb.pop_front());
      load("mid_b", b);
      run_check("mid_b");
   endtask

   task automatic test_hold();
      entrada = rnd_vec();
      repeat (5) @(negedge clk);
      checks++;
      if (flag !== 1'b1) begin
         failures++;
         $display("FAIL hold flag: got %b want 1", flag);
      end
      checks++;
      if (!vec_eq(saida, last.v)) begin
         failures++;
         $display("FAIL hold data: got %s want %s", fmt(saida), fmt(last.v));
      end
   endtask

   task automatic test_back_to_back();
      for (int r = 0; r < 4; r++) begin
         load($sformatf("b2b%0d", r), rnd_vec());
         run_check($sformatf("b2b%0d", r));
         checks++;
         for (int k = 0; k < 8; k++)
            if (saida[k] > saida[k+1]) begin
               failures++;
               $display("FAIL b2b%0d order: got %s", r, fmt(saida));
               break;
            end
      end
   endtask

   initial begin
      for (int k = 0; k < 9; k++) entrada[k] = 8'd0;
      test_reset();
      test_reverse();
      test_random();
      test_hold();
      test_sorted();
      test_midsort();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
